// File: rtl/shift_deserializer_if.sv
// Parallel-side and serial-side signals of the shift deserializer.
// The master drives frame requests and serial beats; the slave returns the assembled word.
interface shift_deserializer_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [1:0]       sel;
  logic             serial_in;
  logic             serial_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             busy;
  logic             err;

  modport master (
    output start, len, sel, serial_in, serial_valid,
    input  out, out_valid, busy, err
  );

  modport slave (
    input  start, len, sel, serial_in, serial_valid,
    output out, out_valid, busy, err
  );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: assembles 1..WIDTH bits MSB- or LSB-first into a
// WIDTH-bit word, zero- or sign-extending short frames.
module shift_deserializer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst,
  shift_deserializer_if.slave bus
);
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [LEN_W-1:0] cnt_reg, cnt_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [1:0]       mode_reg, mode_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic             out_valid_reg, out_valid_next;
  logic             err_reg, err_next;

  logic                    len_ok;
  logic                    last_beat;
  logic [WIDTH-1:0]        shifted;
  logic [WIDTH-1:0]        keep_mask;
  logic [WIDTH-1:0]        top_hot;
  logic                    msb_sign;
  logic [WIDTH-1:0]        msb_word;
  logic [LEN_W-1:0]        drop;
  logic [WIDTH-1:0]        lsb_logic;
  logic signed [WIDTH-1:0] lsb_arith;
  logic [WIDTH-1:0]        lsb_word;
  logic [WIDTH-1:0]        final_word;

  assign len_ok    = (bus.len != '0) && (bus.len <= WIDTH_L);
  assign shifted   = mode_reg[0] ? {bus.serial_in, shreg_reg[WIDTH-1:1]}
                                 : {shreg_reg[WIDTH-2:0], bus.serial_in};
  assign last_beat = (state_reg == SHIFT) && bus.serial_valid
                     && ((cnt_reg + 1'b1) == len_reg);

  // keep_mask covers the received bits of an MSB-first frame; top_hot marks its first bit
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    assign keep_mask[gi] = (LEN_W'(gi) < len_reg);
    assign top_hot[gi]   = (LEN_W'(gi + 1) == len_reg);
  end

  assign msb_sign = |(shifted & top_hot);
  assign msb_word = (shifted & keep_mask)
                    | ((mode_reg[1] && msb_sign) ? ~keep_mask : '0);

  // Arithmetic shift kept in its own signed assignment so it cannot be demoted to logical
  assign drop      = WIDTH_L - len_reg;
  assign lsb_logic = shifted >> drop;
  assign lsb_arith = $signed(shifted) >>> drop;
  assign lsb_word  = mode_reg[1] ? lsb_arith : lsb_logic;

  assign final_word = mode_reg[0] ? lsb_word : msb_word;

  always_comb begin
    state_next     = state_reg;
    shreg_next     = shreg_reg;
    cnt_next       = cnt_reg;
    len_next       = len_reg;
    mode_next      = mode_reg;
    out_next       = out_reg;
    out_valid_next = 1'b0;
    err_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            mode_next  = bus.sel;
            len_next   = bus.len;
            shreg_next = '0;
            cnt_next   = '0;
            state_next = SHIFT;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (bus.start) begin
          err_next = 1'b1;
        end
        if (bus.serial_valid) begin
          shreg_next = shifted;
          cnt_next   = cnt_reg + 1'b1;
        end
        if (last_beat) begin
          out_next       = final_word;
          out_valid_next = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shreg_reg     <= '0;
      cnt_reg       <= '0;
      len_reg       <= '0;
      mode_reg      <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shreg_reg     <= shreg_next;
      cnt_reg       <= cnt_next;
      len_reg       <= len_next;
      mode_reg      <= mode_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
      err_reg       <= err_next;
    end
  end

  assign bus.out       = out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.busy      = (state_reg == SHIFT);
  assign bus.err       = err_reg;
endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel receiver that assembles a frame of 1..WIDTH serial bits into a WIDTH-bit word. It is the receive-side counterpart of our shift datapath: bits are shifted in rather than out. Direction (MSB-first or LSB-first) and extension of short frames (zero or sign) are selected per frame with the same 2-bit logical/arithmetic, left/right encoding the shift unit uses. It sits between a serial link front-end and the parallel datapath.

## Interface
- WIDTH, 8, width of the assembled word; legal range 2..32.
- LEN_W, $clog2(WIDTH+1), width of the frame-length input.

- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame request; sampled only in IDLE.
- len  input  LEN_W  frame length in bits, sampled with start; legal range 1..WIDTH.
- sel  input  2  frame mode, sampled with start:
  - 00: MSB-first, zero-extend.
  - 01: LSB-first, zero-extend.
  - 10: MSB-first, sign-extend.
  - 11: LSB-first, sign-extend.
- serial_in  input  1  data bit; sampled when serial_valid=1 in SHIFT.
- serial_valid  input  1  serial_in is valid this cycle.
- out  output  WIDTH  assembled word; registered; held until the next completion.
- out_valid  output  1  one-cycle pulse: out has just been updated.
- busy  output  1  high while in SHIFT.
- err  output  1  one-cycle pulse: illegal len, or start received while busy.

## Operation
- States: IDLE, SHIFT.
- Internal registers: shreg[WIDTH-1:0], cnt[LEN_W-1:0], mode_q, len_q.
- IDLE, start=1, 1<=len<=WIDTH:
  - latch sel and len;
  - shreg<=0, cnt<=0;
  - go to SHIFT.
- IDLE, start=1, len=0 or len>WIDTH: err=1 for the next cycle; stay in IDLE.
- SHIFT, serial_valid=1:
  - MSB-first (sel[0]=0): shreg<={shreg[WIDTH-2:0],serial_in}.
  - LSB-first (sel[0]=1): shreg<={serial_in,shreg[WIDTH-1:1]}.
  - cnt<=cnt+1.
- SHIFT, serial_valid=0: shreg and cnt hold. Stalls of any length are legal.
- Last bit is the beat with serial_valid=1 and cnt==len_q-1. On the same edge:
  - out<=final value;
  - out_valid<=1;
  - state<=IDLE.
- Final value is formed from the bits after the last shift:
  - MSB-first: bits occupy [len-1:0]; the first bit received is at [len-1].
    - Zero-extend: upper bits 0.
    - Sign-extend: upper bits = first bit received.
  - LSB-first: bits occupy shreg[WIDTH-1:WIDTH-len].
    - Zero-extend: result = shreg>>(WIDTH-len).
    - Sign-extend: result = $signed(shreg)>>>(WIDTH-len), i.e. sign = last bit received.
  - len=WIDTH: no extension applies.
- start in SHIFT: ignored; err pulses. The frame in progress is unaffected.
- serial_valid in IDLE: ignored.

## Timing
- Reset values: out=0, out_valid=0, busy=0, err=0, state=IDLE, shreg=0, cnt=0.
- Reset mid-frame aborts the frame. No out_valid; out returns to 0.
- start accepted on edge N: busy=1 from cycle N+1. The earliest data bit is sampled at edge N+1.
- Last bit sampled at edge M: out_valid=1 and busy=0 during cycle M+1; out_valid returns to 0 at M+2.
- Minimum frame time with no stalls: len+1 cycles, start to out_valid.
- A start during the out_valid cycle is accepted (state is IDLE). Back-to-back frames therefore have no dead cycle.
- err is registered: it is high in the cycle after the offending start.

## Test plan
- WIDTH=8, sel=00, len=4, bits 1,0,1,1 with no stalls -> out=8'h0B; out_valid high exactly 5 cycles after start is sampled.
- sel=10, len=4, bits 1,0,1,1 -> out=8'hFB. Then sel=10, len=4, bits 0,1,0,1 -> out=8'h05.
- sel=01, len=4, bits 1,1,0,1 (LSB-first) -> out=8'h0B. Repeat with sel=11 -> out=8'hFB.
- sel=01, len=8, bits 1,0,1,0,0,1,0,1 with serial_valid low for 3 cycles after bits 2 and 5 -> out=8'hA5.
  - busy stays high throughout the stalls;
  - bits presented while serial_valid=0 are not captured.
- Error cases:
  - start with len=0 -> err pulses, busy stays 0;
  - start with len=9 -> err pulses, busy stays 0;
  - start during a frame -> err pulses, and the frame still completes with the correct value.
- Reset cases:
  - rst asserted after 3 of 8 bits -> busy=0, out=0, no out_valid;
  - a following full frame (sel=00, 8'h3C) completes correctly.
  - start held during the out_valid cycle -> second frame accepted with no gap.
